// File: rtl/jts16_restore.sv
// NVRAM restore path: pairs ioctl bytes into 16-bit words and replays them as masked
// writes into VRAM, char RAM, palette and object RAM, and restores the tile bank.
module jts16_restore #(
   parameter int VRAMW = 14
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ioctl_ram,
   input  logic        ioctl_wr,
   input  logic [16:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        ioctl_wait,
   output logic        cpu_halt,
   output logic        ram_req,
   input  logic        ram_ack,
   output logic [14:0] ram_addr,
   output logic [15:0] ram_din,
   output logic [1:0]  ram_dswn,
   output logic        vram_sel,
   output logic        char_sel,
   output logic        pal_sel,
   output logic        obj_sel,
   output logic [5:0]  tile_bank,
   output logic        ovf
);

   typedef enum logic {IDLE, REQ} state_t;

   state_t      state;
   logic        pend;
   logic [7:0]  hi;
   logic [15:0] pend_waddr;
   logic [3:0]  pend_sel;
   logic        hold_valid;
   logic [16:0] hold_addr;
   logic [7:0]  hold_data;
   logic [3:0]  sel;
   logic        ram_act;

   logic        src_valid;
   logic [16:0] src_addr;
   logic [7:0]  src_data;
   logic [4:0]  src_dec;
   logic        src_miss;

   // Result bits: {tile, obj, pal, char, vram}; all zero means the byte is discarded
   function automatic logic [4:0] decode(input logic [16:0] a);
      logic [4:0] d;
      d = 5'b00000;
      if (VRAMW == 32'sd15) begin
         if (a[16] == 1'b0)                  d = 5'b00001;
         else if (a[16:12] == 5'b10000)      d = 5'b00010;
         else if (a[16:12] == 5'b10001)      d = 5'b00100;
         else if (a[16:11] == 6'b100100)     d = 5'b01000;
         else if (a[16:1] == 16'h9400)       d = 5'b10000;
         else                                d = 5'b00000;
      end else begin
         if (a[16:15] == 2'b00)              d = 5'b00001;
         else if (a[16:12] == 5'b01000)      d = 5'b00010;
         else if (a[16:12] == 5'b01001)      d = 5'b00100;
         else if (a[16:11] == 6'b010100)     d = 5'b01000;
         else                                d = 5'b00000;
      end
      return d;
   endfunction

   assign vram_sel   = sel[0];
   assign char_sel   = sel[1];
   assign pal_sel    = sel[2];
   assign obj_sel    = sel[3];
   assign ioctl_wait = (state == REQ) | hold_valid;
   assign cpu_halt   = ram_act | (state != IDLE) | pend;

   // Byte source for this cycle: a held byte takes priority over a fresh strobe
   always_comb begin
      src_valid = 1'b0;
      src_addr  = ioctl_addr;
      src_data  = ioctl_dout;
      if (state == IDLE) begin
         if (hold_valid) begin
            src_valid = 1'b1;
            src_addr  = hold_addr;
            src_data  = hold_data;
         end else begin
            src_valid = ioctl_wr;
         end
      end else begin
         src_valid = 1'b0;
      end
      src_dec  = decode(src_addr);
      src_miss = pend & (src_addr[16:1] != pend_waddr);
   end

   // Word assembly, request handshake and tile bank restore
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         pend       <= 1'b0;
         hi         <= 8'h00;
         pend_waddr <= 16'h0000;
         pend_sel   <= 4'b0000;
         hold_valid <= 1'b0;
         hold_addr  <= 17'h00000;
         hold_data  <= 8'h00;
         sel        <= 4'b0000;
         ram_act    <= 1'b0;
         ram_req    <= 1'b0;
         ram_addr   <= 15'h0000;
         ram_din    <= 16'h0000;
         ram_dswn   <= 2'b11;
         tile_bank  <= 6'h00;
         ovf        <= 1'b0;
      end else begin
         ram_act <= ioctl_ram;
         if (ioctl_wr && ioctl_wait) begin
            ovf <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (src_valid) begin
                  hold_valid <= 1'b0;
                  if (src_miss) begin
                     // Flush the lone high byte, park the new byte until the ack
                     state      <= REQ;
                     ram_req    <= 1'b1;
                     ram_addr   <= pend_waddr[14:0];
                     ram_din    <= {hi, 8'h00};
                     ram_dswn   <= 2'b01;
                     sel        <= pend_sel;
                     pend       <= 1'b0;
                     hold_valid <= 1'b1;
                     hold_addr  <= src_addr;
                     hold_data  <= src_data;
                  end else if (!src_addr[0]) begin
                     if (|src_dec[3:0]) begin
                        hi         <= src_data;
                        pend       <= 1'b1;
                        pend_waddr <= src_addr[16:1];
                        pend_sel   <= src_dec[3:0];
                     end
                  end else if (src_dec[4]) begin
                     tile_bank <= src_data[5:0];
                     pend      <= 1'b0;
                  end else if (|src_dec[3:0]) begin
                     state    <= REQ;
                     ram_req  <= 1'b1;
                     ram_addr <= src_addr[15:1];
                     ram_din  <= {(pend ? hi : 8'h00), src_data};
                     ram_dswn <= pend ? 2'b00 : 2'b10;
                     sel      <= src_dec[3:0];
                     pend     <= 1'b0;
                  end else begin
                     pend <= 1'b0;
                  end
               end else if (pend && !ioctl_ram) begin
                  state    <= REQ;
                  ram_req  <= 1'b1;
                  ram_addr <= pend_waddr[14:0];
                  ram_din  <= {hi, 8'h00};
                  ram_dswn <= 2'b01;
                  sel      <= pend_sel;
                  pend     <= 1'b0;
               end
            end
            REQ: begin
               if (ram_ack) begin
                  state    <= IDLE;
                  ram_req  <= 1'b0;
                  ram_dswn <= 2'b11;
                  sel      <= 4'b0000;
               end
            end
            default: begin
               state    <= IDLE;
               ram_req  <= 1'b0;
               ram_dswn <= 2'b11;
               sel      <= 4'b0000;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jts16_restore.sv
// Directed bench for jts16_restore: one instance per address map (VRAMW=14 and 15).
module tb_jts16_restore;

   logic        clk;
   logic        rst_n;
   logic        ioctl_ram;
   logic        wr14, wr15;
   logic [16:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        ack14, ack15;

   logic        wait14, halt14, req14, vsel14, csel14, psel14, osel14, ovf14;
   logic [14:0] addr14;
   logic [15:0] din14;
   logic [1:0]  dswn14;
   logic [5:0]  tile14;
   logic        wait15, halt15, req15, vsel15, csel15, psel15, osel15, ovf15;
   logic [14:0] addr15;
   logic [15:0] din15;
   logic [1:0]  dswn15;
   logic [5:0]  tile15;

   int checks;
   int errors;

   jts16_restore #(.VRAMW(14)) dut14 (
      .clk(clk), .rst_n(rst_n), .ioctl_ram(ioctl_ram), .ioctl_wr(wr14),
      .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(wait14),
      .cpu_halt(halt14), .ram_req(req14), .ram_ack(ack14), .ram_addr(addr14),
      .ram_din(din14), .ram_dswn(dswn14), .vram_sel(vsel14), .char_sel(csel14),
      .pal_sel(psel14), .obj_sel(osel14), .tile_bank(tile14), .ovf(ovf14)
   );

   jts16_restore #(.VRAMW(15)) dut15 (
      .clk(clk), .rst_n(rst_n), .ioctl_ram(ioctl_ram), .ioctl_wr(wr15),
      .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(wait15),
      .cpu_halt(halt15), .ram_req(req15), .ram_ack(ack15), .ram_addr(addr15),
      .ram_din(din15), .ram_dswn(dswn15), .vram_sel(vsel15), .char_sel(csel15),
      .pal_sel(psel15), .obj_sel(osel15), .tile_bank(tile15), .ovf(ovf15)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One-cycle strobe; returns 1 ns after the edge that sampled it
   task automatic wr_byte(input logic which, input logic [16:0] a, input logic [7:0] d);
      @(posedge clk); #1;
      ioctl_addr = a;
      ioctl_dout = d;
      if (which) wr15 = 1'b1; else wr14 = 1'b1;
      @(posedge clk); #1;
      wr14 = 1'b0;
      wr15 = 1'b0;
   endtask

   task automatic ack_pulse(input logic which);
      @(posedge clk); #1;
      if (which) ack15 = 1'b1; else ack14 = 1'b1;
      @(posedge clk); #1;
      ack14 = 1'b0;
      ack15 = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      ioctl_ram = 1'b0;
      wr14 = 1'b0; wr15 = 1'b0;
      ioctl_addr = 17'h00000;
      ioctl_dout = 8'h00;
      ack14 = 1'b0; ack15 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req", {31'd0, req14}, 32'd0);
      check("rst_dswn", {30'd0, dswn14}, 32'd3);
      check("rst_wait", {31'd0, wait14}, 32'd0);
      check("rst_halt", {31'd0, halt14}, 32'd0);
      check("rst_tile", {26'd0, tile15}, 32'd0);
      rst_n = 1'b1;
      ioctl_ram = 1'b1;

      // Full word to VRAM
      wr_byte(1'b0, 17'h00100, 8'h12);
      check("t1_no_req_even", {31'd0, req14}, 32'd0);
      check("t1_halt", {31'd0, halt14}, 32'd1);
      wr_byte(1'b0, 17'h00101, 8'h34);
      check("t1_req", {31'd0, req14}, 32'd1);
      check("t1_addr", {17'd0, addr14}, 32'h080);
      check("t1_din", {16'd0, din14}, 32'h1234);
      check("t1_dswn", {30'd0, dswn14}, 32'd0);
      check("t1_vsel", {28'd0, osel14, psel14, csel14, vsel14}, 32'b0001);
      repeat (2) @(posedge clk);
      #1;
      check("t1_req_held", {31'd0, req14}, 32'd1);
      ack_pulse(1'b0);
      check("t1_req_drop", {31'd0, req14}, 32'd0);
      check("t1_dswn_idle", {30'd0, dswn14}, 32'd3);

      // Palette word, slow ack, strobe during wait is dropped
      wr_byte(1'b0, 17'h09000, 8'hAB);
      check("t2_wait_pend", {31'd0, wait14}, 32'd0);
      wr_byte(1'b0, 17'h09001, 8'hCD);
      check("t2_psel", {28'd0, osel14, psel14, csel14, vsel14}, 32'b0100);
      check("t2_din", {16'd0, din14}, 32'hABCD);
      check("t2_wait", {31'd0, wait14}, 32'd1);
      check("t2_ovf0", {31'd0, ovf14}, 32'd0);
      wr_byte(1'b0, 17'h09002, 8'hEE);
      check("t2_ovf", {31'd0, ovf14}, 32'd1);
      check("t2_wait_hold", {31'd0, wait14}, 32'd1);
      ack_pulse(1'b0);
      check("t2_wait_drop", {31'd0, wait14}, 32'd0);
      check("t2_req_drop", {31'd0, req14}, 32'd0);

      // Mismatched word: flush high byte, then odd-only byte
      wr_byte(1'b0, 17'h08002, 8'h55);
      wr_byte(1'b0, 17'h08005, 8'h66);
      check("t3_f_req", {31'd0, req14}, 32'd1);
      check("t3_f_addr", {17'd0, addr14}, 32'h4001);
      check("t3_f_din_hi", {24'd0, din14[15:8]}, 32'h55);
      check("t3_f_dswn", {30'd0, dswn14}, 32'd1);
      check("t3_f_csel", {28'd0, osel14, psel14, csel14, vsel14}, 32'b0010);
      check("t3_f_wait", {31'd0, wait14}, 32'd1);
      ack_pulse(1'b0);
      check("t3_gap_req", {31'd0, req14}, 32'd0);
      check("t3_gap_wait", {31'd0, wait14}, 32'd1);
      @(posedge clk); #1;
      check("t3_req", {31'd0, req14}, 32'd1);
      check("t3_addr", {17'd0, addr14}, 32'h4002);
      check("t3_din", {16'd0, din14}, 32'h0066);
      check("t3_dswn", {30'd0, dswn14}, 32'd2);
      ack_pulse(1'b0);
      check("t3_ovf_sticky", {31'd0, ovf14}, 32'd1);

      // 64 kB map: tile bank, discarded range, VRAM upper half
      wr_byte(1'b1, 17'h12801, 8'h2A);
      check("t4_tile", {26'd0, tile15}, 32'h2A);
      check("t4_tile_noreq", {31'd0, req15}, 32'd0);
      wr_byte(1'b1, 17'h13000, 8'h11);
      wr_byte(1'b1, 17'h13001, 8'h22);
      check("t4_disc_noreq", {31'd0, req15}, 32'd0);
      check("t4_disc_nosel", {28'd0, osel15, psel15, csel15, vsel15}, 32'd0);
      wr_byte(1'b1, 17'h0C000, 8'hAA);
      wr_byte(1'b1, 17'h0C001, 8'hBB);
      check("t4_v_req", {31'd0, req15}, 32'd1);
      check("t4_v_sel", {28'd0, osel15, psel15, csel15, vsel15}, 32'b0001);
      check("t4_v_addr", {17'd0, addr15}, 32'h6000);
      check("t4_v_din", {16'd0, din15}, 32'hAABB);
      ack_pulse(1'b1);
      wr_byte(1'b1, 17'h11002, 8'h3C);
      wr_byte(1'b1, 17'h11003, 8'h4D);
      check("t4_p_sel", {28'd0, osel15, psel15, csel15, vsel15}, 32'b0100);
      check("t4_p_addr", {17'd0, addr15}, 32'h0801);
      ack_pulse(1'b1);

      // Pending high byte flushed when the transfer ends
      wr_byte(1'b0, 17'h0A010, 8'h77);
      ioctl_ram = 1'b0;
      @(posedge clk); #1;
      check("t5_req", {31'd0, req14}, 32'd1);
      check("t5_osel", {28'd0, osel14, psel14, csel14, vsel14}, 32'b1000);
      check("t5_dswn", {30'd0, dswn14}, 32'd1);
      check("t5_din_hi", {24'd0, din14[15:8]}, 32'h77);
      check("t5_addr", {17'd0, addr14}, 32'h5008);
      check("t5_halt", {31'd0, halt14}, 32'd1);
      ack_pulse(1'b0);
      check("t5_halt_drop", {31'd0, halt14}, 32'd0);
      check("t5_req_drop", {31'd0, req14}, 32'd0);

      // Asynchronous reset in the middle of a request
      ioctl_ram = 1'b1;
      wr_byte(1'b0, 17'h00200, 8'h01);
      wr_byte(1'b0, 17'h00201, 8'h02);
      check("t6_req_pre", {31'd0, req14}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_req", {31'd0, req14}, 32'd0);
      check("t6_wait", {31'd0, wait14}, 32'd0);
      check("t6_halt", {31'd0, halt14}, 32'd0);
      check("t6_tile", {26'd0, tile15}, 32'd0);
      check("t6_dswn", {30'd0, dswn14}, 32'd3);
      check("t6_ovf", {31'd0, ovf14}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/jts16_restore.md
Name: jts16_restore

Overview:
- Reverse path of the NVRAM shadow dump: accepts the byte stream written back through the MiSTer ioctl NVRAM interface and rebuilds the game's VRAM, char RAM, palette, object RAM and tile bank.
- Pairs bytes into 16-bit words, decodes the target RAM from the address, and performs one masked write per word through a req/ack port into the game's RAM write mux.
- Holds the CPU off the bus and back-pressures hps_io while a write is outstanding.

Parameters:
- VRAMW, 14, VRAM word-address width. 14 selects the 32 kB map; 15 selects the 64 kB map.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- ioctl_ram  in  1  NVRAM transfer active
- ioctl_wr  in  1  one-cycle byte strobe
- ioctl_addr  in  17  byte address
- ioctl_dout  in  8  byte data
- ioctl_wait  out  1  back-pressure to hps_io
- cpu_halt  out  1  keeps the CPU off the RAM buses
- ram_req  out  1  write request
- ram_ack  in  1  one-cycle write accept
- ram_addr  out  15  word address [15:1]
- ram_din  out  16  write data
- ram_dswn  out  2  byte write mask, active low; [1]=high byte
- vram_sel, char_sel, pal_sel, obj_sel  out  1 each  target select, one-hot, valid while ram_req is high
- tile_bank  out  6  restored tile bank register
- ovf  out  1  sticky: byte dropped

Behaviour:
- Reset values: all outputs 0, except ram_dswn=2'b11. FSM resets to IDLE and the pending-byte flag is cleared.
- Byte order: even ioctl_addr carries the high byte [15:8]; odd carries the low byte [7:0].
- Address map, VRAMW=14:
  - 0x0000-0x7FFF: VRAM
  - 0x8000-0x8FFF: char
  - 0x9000-0x9FFF: pal
  - 0xA000-0xA7FF: obj
  - anything else: discarded, no request issued
- Address map, VRAMW=15:
  - addr[16]=0: VRAM
  - 0x10000-0x10FFF: char
  - 0x11000-0x11FFF: pal
  - 0x12000-0x127FF: obj
  - 0x12800-0x12801: tile_bank; the low byte (odd address) loads tile_bank <= byte[5:0] internally, no request issued
  - anything else: discarded
- ram_addr = ioctl_addr[15:1], truncated by the target size in the game's RAMs.
- FSM states:
  - IDLE:
    - Even byte: latch it as the high byte, set pending, remember the word address, stay in IDLE.
    - Odd byte, pending and same word address: data = {hi, lo}, dswn=00, go to REQ.
    - Odd byte, not pending: data = {8'h00, lo}, dswn=10, go to REQ.
  - Mismatched word:
    - Trigger: an even or odd byte arrives while pending with a different word address.
    - First flush the pending high byte alone (dswn=01, REQ), with ioctl_wait=1.
    - Process the new byte in the cycle after the flush is acknowledged, from an internal one-byte holding register.
  - REQ: ram_req=1; addr, data, mask and sel are stable until the ram_ack cycle. On ack: ram_req=0 in the next cycle, return to IDLE or service the held byte.
  - Latency: odd strobe to ram_req is 1 cycle.
- ioctl_wait=1 in REQ and while a held byte exists. A strobe arriving while the holding register is full is dropped and sets ovf; ovf clears only on reset.
- Falling edge of ioctl_ram with pending set: flush the high byte (dswn=01) before going idle.
- cpu_halt = ioctl_ram OR (FSM not IDLE) OR pending.
- Discarded addresses still clear pending if the word address differs, and flush it first.
- rst_n low mid-REQ: ram_req drops asynchronously. The partial word is lost and tile_bank returns to 0.

Test Plan:
- VRAMW=14: write 0x12 @0x0100 then 0x34 @0x0101 -> one ram_req, ram_addr=0x080, ram_din=0x1234, ram_dswn=00, vram_sel=1, ram_req 1 cycle after the second strobe, held until ack.
- VRAMW=14: bytes 0xAB @0x9000, 0xCD @0x9001, ack delayed 5 cycles -> pal_sel=1, ram_din=0xABCD; ioctl_wait high for exactly those cycles; a third strobe during wait sets ovf=1.
- Even 0x55 @0x8002, then odd 0x66 @0x8005 -> flush {0x55,xx} dswn=01 addr 0x4001 char_sel, then {0x00,0x66} dswn=10 addr 0x4002.
- VRAMW=15: byte 0x2A @0x12801 -> tile_bank=6'h2A, no ram_req; byte @0x13000 -> no ram_req, no sel.
- Even 0x77 @0xA010, then ioctl_ram falls -> single obj write dswn=01 data[15:8]=0x77; cpu_halt drops after ack.
- Assert rst_n=0 while ram_req=1 -> ram_req, ioctl_wait, cpu_halt, tile_bank all 0 immediately; ram_dswn=11.
